// File: rtl/spi_master_frame.sv
// SPI master: DATA_W-bit full-duplex words, configurable CPOL/CPHA/bit order,
// multi-word frames with chip select held between words.
module spi_master_frame #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 64,
  parameter int NUM_CS    = 1,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   tx_cs,
  input  logic              tx_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int TOG_W = $clog2(2*DATA_W + 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP, HOLD} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [TOG_W-1:0]  tog_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh, tx_next, rx_next;
  logic [NUM_CS-1:0] cs_dec;
  logic              last_q;
  logic              tick, leading, xfer_tick, sample_en, drive_en, last_tog;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // Out-of-range select indices leave every line deasserted.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (int'(tx_cs) == i) cs_dec[i] = 1'b0;
  end

  // tog_cnt holds the number of toggles already done; an even count means
  // the upcoming toggle is a leading edge.
  always_comb begin
    tick      = (div == DIV_W'(CLK_DIV - 1));
    leading   = ~tog_cnt[0];
    xfer_tick = (state == XFER) && tick;
    last_tog  = xfer_tick && (tog_cnt == TOG_W'(2*DATA_W - 1));
    sample_en = xfer_tick && (leading ^ CPHA);
    drive_en  = xfer_tick && (CPHA ? (leading && (tog_cnt != '0)) : (!leading && !last_tog));
    tx_next   = shift_out(tx_sh);
    rx_next   = sample_en ? shift_in(rx_sh, miso) : rx_sh;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      div      <= '0;
      tog_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      last_q   <= 1'b0;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      cs_n     <= '1;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // Every transition happens on a tick or out of IDLE/HOLD, so this also
      // clears the divider on state entry.
      div <= (state == IDLE || state == HOLD || tick) ? '0 : div + 1'b1;
      unique case (state)
        IDLE: if (tx_valid) begin
          tx_sh    <= tx_data;
          mosi     <= first_bit(tx_data);
          last_q   <= tx_last;
          cs_n     <= cs_dec;
          tx_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= LEAD;
        end
        LEAD: if (tick) begin
          tog_cnt <= '0;
          state   <= XFER;
        end
        XFER: if (tick) begin
          sclk    <= ~sclk;
          tog_cnt <= tog_cnt + 1'b1;
          rx_sh   <= rx_next;
          if (drive_en) begin
            tx_sh <= tx_next;
            mosi  <= first_bit(tx_next);
          end
          if (last_tog) begin
            if (last_q) state <= TRAIL;
            else begin
              state    <= HOLD;
              tx_ready <= 1'b1;
              rx_valid <= 1'b1;
              rx_data  <= rx_next;
            end
          end
        end
        TRAIL: if (tick) begin
          cs_n     <= '1;
          rx_valid <= 1'b1;
          rx_data  <= rx_sh;
          state    <= GAP;
        end
        GAP: if (tick) begin
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        HOLD: if (tx_valid) begin
          tx_sh    <= tx_data;
          mosi     <= first_bit(tx_data);
          last_q   <= tx_last;
          tog_cnt  <= '0;
          tx_ready <= 1'b0;
          state    <= XFER;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
